// File: rtl/cpu_phase_alu_if.sv
// Execution back-end bus: operand/opcode inputs, phase strobes, result and load code.
// EXEC_FLAGS_EN adds zero_flag/carry_flag to the bus.
interface cpu_phase_alu_if #(
  parameter int WIDTH = 32
);
  logic             clock_1, clock_2, clock_3, clock_4;
  logic             clock_5, clock_6, clock_7, clock_8;
  logic [31:0]      ope;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       reg_load_1;
  logic [3:0]       reg_load_2;
  logic [WIDTH-1:0] alu_result_bus;
  logic [3:0]       selected_reg_load;
`ifdef EXEC_FLAGS_EN
  logic             zero_flag;
  logic             carry_flag;
`endif

  modport master (
    output ope, operand_a, operand_b, reg_load_1, reg_load_2,
`ifdef EXEC_FLAGS_EN
    input  zero_flag, carry_flag,
`endif
    input  clock_1, clock_2, clock_3, clock_4,
    input  clock_5, clock_6, clock_7, clock_8,
    input  alu_result_bus, selected_reg_load
  );

  modport slave (
    input  ope, operand_a, operand_b, reg_load_1, reg_load_2,
`ifdef EXEC_FLAGS_EN
    output zero_flag, carry_flag,
`endif
    output clock_1, clock_2, clock_3, clock_4,
    output clock_5, clock_6, clock_7, clock_8,
    output alu_result_bus, selected_reg_load
  );
endinterface

// File: rtl/cpu_phase_alu.sv
// Multi-phase CPU execution back-end: 8-phase one-hot sequencer, two-step ALU, load-code selector.
// Optional EXEC_FLAGS_EN adds zero/carry flags updated alongside the result.
module cpu_phase_alu #(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  cpu_phase_alu_if.slave bus
);

  typedef enum logic [7:0] {
    PH_IDLE = 8'h00,
    PH_1    = 8'h01,
    PH_2    = 8'h02,
    PH_3    = 8'h04,
    PH_4    = 8'h08,
    PH_5    = 8'h10,
    PH_6    = 8'h20,
    PH_7    = 8'h40,
    PH_8    = 8'h80
  } phase_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  phase_t           phase;
  logic [7:0]       op;
  logic [23:0]      imm_le;
  logic [WIDTH-1:0] a, b, imm, sum;
  logic [WIDTH-1:0] step1, step2;
  logic [WIDTH-1:0] result;
`ifdef EXEC_FLAGS_EN
  logic             c1, c2;
  logic             zero_q, carry_q;
`endif

  // The phase register doubles as the strobe outputs; idle (all zero) only after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= PH_IDLE;
    end else begin
      case (phase)
        PH_IDLE: phase <= PH_1;
        PH_1:    phase <= PH_2;
        PH_2:    phase <= PH_3;
        PH_3:    phase <= PH_4;
        PH_4:    phase <= PH_5;
        PH_5:    phase <= PH_6;
        PH_6:    phase <= PH_7;
        PH_7:    phase <= PH_8;
        PH_8:    phase <= PH_1;
        default: phase <= PH_IDLE;
      endcase
    end
  end

  assign bus.clock_1 = phase[0];
  assign bus.clock_2 = phase[1];
  assign bus.clock_3 = phase[2];
  assign bus.clock_4 = phase[3];
  assign bus.clock_5 = phase[4];
  assign bus.clock_6 = phase[5];
  assign bus.clock_7 = phase[6];
  assign bus.clock_8 = phase[7];

  assign op     = bus.ope[31:24];
  assign imm_le = {bus.ope[7:0], bus.ope[15:8], bus.ope[23:16]};
  assign imm    = WIDTH'(imm_le);
  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign sum    = a + b;

  always_comb begin
    step1 = b;
    step2 = b;
`ifdef EXEC_FLAGS_EN
    c1 = 1'b0;
    c2 = 1'b0;
`endif
    case (op) inside
      [8'h50:8'h57]: begin
        step1 = b - STEP;
`ifdef EXEC_FLAGS_EN
        c1 = (b < STEP);
`endif
      end
      [8'h58:8'h5F]: step2 = b + STEP;
      [8'hB8:8'hBF]: begin
        step1 = imm;
        step2 = imm;
      end
      8'h01: begin
        step1 = sum;
        step2 = sum;
`ifdef EXEC_FLAGS_EN
        // Unsigned wrap of the sum below an addend is exactly the carry-out.
        c1 = (sum < a);
        c2 = (sum < a);
`endif
      end
      8'h29: begin
        step1 = b - a;
        step2 = b - a;
`ifdef EXEC_FLAGS_EN
        c1 = (b < a);
        c2 = (b < a);
`endif
      end
      8'h31: begin
        step1 = a ^ b;
        step2 = a ^ b;
      end
      8'h21: begin
        step1 = a & b;
        step2 = a & b;
      end
      8'h09: begin
        step1 = a | b;
        step2 = a | b;
      end
      default: begin
        step1 = b;
        step2 = b;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
`ifdef EXEC_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else if (phase == PH_3) begin
      result <= step1;
`ifdef EXEC_FLAGS_EN
      zero_q  <= (step1 == '0);
      carry_q <= c1;
`endif
    end else if (phase == PH_5) begin
      result <= step2;
`ifdef EXEC_FLAGS_EN
      zero_q  <= (step2 == '0);
      carry_q <= c2;
`endif
    end
  end

  assign bus.alu_result_bus = result;
`ifdef EXEC_FLAGS_EN
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
`endif

  always_comb begin
    bus.selected_reg_load = '0;
    if (phase == PH_4)
      bus.selected_reg_load = bus.reg_load_1;
    else if (phase == PH_6)
      bus.selected_reg_load = bus.reg_load_2;
  end

endmodule

// File: tb/tb_cpu_phase_alu.sv
// Directed self-checking bench for cpu_phase_alu; flag checks compile in with EXEC_FLAGS_EN.
module tb_cpu_phase_alu;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] strobes;

  cpu_phase_alu_if #(.WIDTH(32)) bus ();

  cpu_phase_alu #(.WIDTH(32), .STACK_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign strobes = {bus.clock_8, bus.clock_7, bus.clock_6, bus.clock_5,
                    bus.clock_4, bus.clock_3, bus.clock_2, bus.clock_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance on falling edges until phase n is active; bounded.
  task automatic goto_phase(input int n);
    for (int k = 0; k < 16; k++) begin
      if (strobes[n-1] === 1'b1) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL goto_phase%0d: observed=%h expected=phase%0d within 16 cycles", n, strobes, n);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ope, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                        input logic cf1, input logic cf2);
    bus.ope       = ope;
    bus.operand_a = a;
    bus.operand_b = b;
    goto_phase(4);
    chk({tag, "_s1"}, bus.alu_result_bus, e1);
`ifdef EXEC_FLAGS_EN
    chk({tag, "_z1"}, 32'(bus.zero_flag), 32'(e1 == 32'h0));
    chk({tag, "_c1"}, 32'(bus.carry_flag), 32'(cf1));
`endif
    goto_phase(6);
    chk({tag, "_s2"}, bus.alu_result_bus, e2);
`ifdef EXEC_FLAGS_EN
    chk({tag, "_z2"}, 32'(bus.zero_flag), 32'(e2 == 32'h0));
    chk({tag, "_c2"}, 32'(bus.carry_flag), 32'(cf2));
`endif
    goto_phase(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ope        = 32'h5500_0000;
    bus.operand_a  = 32'h0;
    bus.operand_b  = 32'h0000_0100;
    bus.reg_load_1 = 4'd2;
    bus.reg_load_2 = 4'd5;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'(strobes), 32'h0);
    chk("rst_result", bus.alu_result_bus, 32'h0);
    chk("rst_sel", 32'(bus.selected_reg_load), 32'h0);
    reset = 1'b0;

    // Full phase walk with push 0x55, B=0x100.
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      chk($sformatf("phase%0d", p + 1), 32'(strobes), 32'(8'h01 << p));
      if (p == 3) begin
        chk("push_s1", bus.alu_result_bus, 32'h0000_00FC);
        chk("sel_ph4", 32'(bus.selected_reg_load), 32'd2);
      end
      if (p == 5) begin
        chk("push_s2", bus.alu_result_bus, 32'h0000_0100);
        chk("sel_ph6", 32'(bus.selected_reg_load), 32'd5);
      end
      if (p == 6) chk("sel_ph7", 32'(bus.selected_reg_load), 32'd0);
    end
    @(negedge clk);
    chk("wrap_phase1", 32'(strobes), 32'h01);

    run_op("movimm2",  32'hB802_0000, 32'h0,         32'h1234_5678, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0);
    run_op("movimm24", 32'hB856_3412, 32'h0,         32'h1234_5678, 32'h0012_3456, 32'h0012_3456, 1'b0, 1'b0);
    run_op("add_wrap", 32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    run_op("pop_wrap", 32'h5800_0000, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0);
    run_op("push_0",   32'h5000_0000, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub",      32'h2900_0000, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b1);
    run_op("xor",      32'h3100_0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 1'b0, 1'b0);
    run_op("and",      32'h2100_0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'hF000_F000, 1'b0, 1'b0);
    run_op("or",       32'h0900_0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run_op("other",    32'h9000_0000, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // mov: inputs changed outside phases 3/5 must not disturb the held result.
    bus.ope       = 32'h8900_0000;
    bus.operand_b = 32'h1111_1111;
    goto_phase(4);
    chk("mov_s1", bus.alu_result_bus, 32'h1111_1111);
    bus.operand_b = 32'h2222_2222;
    goto_phase(5);
    chk("mov_hold5", bus.alu_result_bus, 32'h1111_1111);
    goto_phase(7);
    chk("mov_s2", bus.alu_result_bus, 32'h2222_2222);
    bus.operand_b = 32'h3333_3333;
    goto_phase(8);
    chk("mov_hold8", bus.alu_result_bus, 32'h2222_2222);
    goto_phase(1);

    // Reset in phase 5 aborts the cycle.
    bus.operand_b = 32'h0000_0077;
    goto_phase(5);
    chk("pre_rst_result", bus.alu_result_bus, 32'h0000_0077);
    reset = 1'b1;
    #1;
    chk("midrst_strobes", 32'(strobes), 32'h0);
    chk("midrst_result", bus.alu_result_bus, 32'h0);
    chk("midrst_sel", 32'(bus.selected_reg_load), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_ph1", 32'(strobes), 32'h01);
    chk("restart_res1", bus.alu_result_bus, 32'h0);
    goto_phase(3);
    chk("restart_res3", bus.alu_result_bus, 32'h0);
    goto_phase(4);
    chk("restart_res4", bus.alu_result_bus, 32'h0000_0077);
    chk("restart_sel4", 32'(bus.selected_reg_load), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_phase_alu.md
Name: cpu_phase_alu

Overview:
- Execution back-end of the multi-phase CPU. Combines three functions:
  - an 8-phase one-hot cycle sequencer;
  - a two-step ALU driven by the fetched opcode word;
  - a result-destination selector that routes the first or second micro-op's register-load code onto the result bus phases.
- Sits between decode/selector (inputs) and the register file/stack memory (consumers of the result bus and load code).

Parameters:
- WIDTH, 32, datapath width of operands and result.
- STACK_STEP, 4, byte delta applied to the stack pointer by push/pop.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clock_1..clock_8  out  1 each  one-hot phase strobes
- ope  in  32  fetched instruction word; ope[31:24] is the opcode byte
- operand_a  in  WIDTH  secondary operand (tie to 0 when unused)
- operand_b  in  WIDTH  selected register output (from selector)
- reg_load_1  in  4  destination code for micro-op 1
- reg_load_2  in  4  destination code for micro-op 2
- alu_result_bus  out  WIDTH  registered ALU result
- selected_reg_load  out  4  active destination code; 0 means no load

Behaviour:
- Sequencer:
  - Reset forces all strobes to 0.
  - The first clk rising edge after reset deasserts raises clock_1. Each subsequent edge advances clock_1→2→…→8→1.
  - Exactly one strobe is high at any time outside reset; each strobe is high for one clk period.
- ALU step timing:
  - Step 1 is computed on the edge ending phase 3 and is valid during phases 4–5.
  - Step 2 is computed on the edge ending phase 5 and is valid during phases 6–8.
  - Both steps are computed from ope, operand_a and operand_b sampled at that edge.
  - alu_result_bus holds its value at all other edges.
- Opcode decode (op = ope[31:24]):
  - 0x50–0x57 push: step1 = B − STACK_STEP; step2 = B.
  - 0x58–0x5F pop: step1 = B; step2 = B + STACK_STEP.
  - 0x89 mov: step1 = B; step2 = B.
  - 0xB8–0xBF mov imm: both steps = zero-extended {ope[7:0], ope[15:8], ope[23:16]}, i.e. the little-endian 24-bit immediate.
  - 0x01 add: A + B.
  - 0x29 sub: B − A.
  - 0x31 xor: A ^ B.
  - 0x21 and: A & B.
  - 0x09 or: A | B.
  - The five logic/arith ops give the same value for both steps.
  - Any other opcode: pass B.
- Width and wrap rules:
  - All arithmetic is modulo 2^WIDTH.
  - Wrap is silent: 0 − 4 = 0xFFFFFFFC, and 0xFFFFFFFF + 1 = 0.
- Result selector:
  - selected_reg_load = reg_load_1 while clock_4 is high.
  - selected_reg_load = reg_load_2 while clock_6 is high.
  - selected_reg_load = 0 otherwise.
  - It is combinational from the strobes and is registered nowhere else.
- Reset:
  - alu_result_bus = 0, selected_reg_load = 0, all strobes = 0.
  - Asserting reset mid-cycle aborts immediately; the next cycle restarts at phase 1.
- Input changes during phases other than 3 and 5 do not affect alu_result_bus.

Optional Feature:
- EXEC_FLAGS_EN
  - Defined: adds outputs zero_flag and carry_flag. Both update on the same edges as alu_result_bus.
  - zero_flag = 1 when the new result is 0.
  - carry_flag = carry-out of add, or borrow of sub/push decrement; 0 for other ops.
  - Both flags reset to 0.
  - Undefined: the ports and logic are absent.

Test Plan:
- Reset released → clock_1 high one edge later; strobes cycle 1..8 and back to 1 with exactly one strobe high each cycle.
- ope=0x55000000, B=0x00000100, reg_load_1=2, reg_load_2=5 → phase 4: result 0x000000FC, sel_load 2; phase 6: result 0x00000100, sel_load 5; phase 7: sel_load 0.
- ope=0xB8020000 → result 0x00000002 in phases 4 and 6; ope=0xB8563412 → 0x00123456.
- ope=0x01000000, A=0xFFFFFFFF, B=1 → result 0 (and with EXEC_FLAGS_EN: zero_flag=1, carry_flag=1).
- ope=0x58000000, B=0xFFFFFFFC → step2 result 0x00000000 (wrap).
- Reset asserted during phase 5 → all outputs 0 at once; after release the sequence restarts at clock_1 and the result stays 0 until phase 4.
